ingress_requester: RTL and testbench
====================================

INGRESS_REQUESTER -- requirements
Module: ingress_requester

Interface
REQ-001 Parameters SHALL be (name, default, meaning): N_PORTS, 4, number of egress ports; IDX_WIDTH, $clog2(N_PORTS), destination index width; DATA_WIDTH, 8, beat width; DEPTH, 16, FIFO entries, power of two >= 2.
REQ-002 Ports SHALL be (name  direction  width  meaning): clk  in  1  clock; reset  in  1  synchronous active-high reset; one clock domain.
REQ-003 s_data  in  DATA_WIDTH  upstream beat; s_valid  in  1  beat valid; s_last  in  1  final beat of frame; s_ready  out  1  beat accepted when s_valid && s_ready.
REQ-004 out_data  out  DATA_WIDTH  head beat; out_valid  out  1  request to schedulers; out_last  out  1  head is final beat; out_dst  out  IDX_WIDTH  head frame destination; out_ready  in  1  OR of all scheduler ingress_ready bits for this port.
REQ-005 drop_pulse  out  1  one-cycle pulse per dropped frame; drop_count  out  16  dropped-frame count; frame_count  out  $clog2(DEPTH)+1  complete frames held.

Function
REQ-006 Each FIFO entry SHALL store {dst, last, data}; all beats of a frame carry the same dst.
REQ-007 dst SHALL be s_data[IDX_WIDTH-1:0] of a frame's first accepted beat; that beat is also stored and forwarded.
REQ-008 Write FSM states SHALL be WR_HDR (next beat starts a frame), WR_BODY, WR_DROP; reset state WR_HDR.
REQ-009 WR_HDR: accepted beat with s_last=0 -> WR_BODY; with s_last=1 -> commit, stay WR_HDR.
REQ-010 WR_BODY: accepted beat with s_last=1 -> commit, WR_HDR.
REQ-011 Commit SHALL copy the speculative write pointer to the committed write pointer and increment frame_count in the same cycle as the last beat is accepted.
REQ-012 Pointers SHALL be $clog2(DEPTH)+1 bits with wrap-around; full when speculative write pointer minus read pointer equals DEPTH.
REQ-013 s_ready SHALL be 1 in WR_DROP; otherwise 1 unless full.
REQ-014 Overflow: if full and uncommitted beats equal DEPTH, s_ready SHALL stay 1; the offered beat is discarded, speculative pointer rewinds to committed pointer, drop_pulse asserts next cycle; state -> WR_DROP if s_last=0, else WR_HDR.
REQ-015 WR_DROP SHALL discard all beats; on accepted s_last -> WR_HDR.
REQ-016 A frame of exactly DEPTH beats SHALL be accepted without drop.
REQ-017 out_valid SHALL equal (frame_count != 0); partial frames are never presented, so out_valid never drops mid-frame.
REQ-018 out_data/out_last/out_dst SHALL be the entry at the read pointer, combinational from storage, zero latency.
REQ-019 Read SHALL occur on out_valid && out_ready; read of a beat with last=1 decrements frame_count.
REQ-020 Simultaneous commit and last-beat read SHALL leave frame_count unchanged.
REQ-021 Write and read in the same cycle SHALL both complete when full by committed frames is not the case; a committed-full FIFO back-pressures (s_ready=0) and a same-cycle read frees the entry next cycle only.
REQ-022 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-023 reset SHALL clear all pointers, frame_count, drop_count, drop_pulse, and set WR_HDR; outputs after reset: out_valid=0, s_ready=1, drop_pulse=0, drop_count=0, frame_count=0.
REQ-024 Reset mid-frame SHALL discard all stored and partial frames; FIFO storage contents need not be cleared.

Configuration
REQ-025 Macro INGRESS_DROP_CNT_EN defined: drop_count SHALL increment by 1 per drop_pulse, saturating at 16'hFFFF.
REQ-026 Macro INGRESS_DROP_CNT_EN undefined: drop_count SHALL be tied to 0 and no counter logic built; drop_pulse unaffected.

Verification
REQ-027 Frame 3 beats {0x02,0xA1,0xB2}, out_ready=1 -> out_valid rises cycle after last accepted; out_dst=2 for all 3 beats; out_last only on 0xB2.
REQ-028 Frame 4 beats with out_ready=0 for 10 cycles -> out_valid stays 1, frame_count=1, then 4 reads on out_ready=1 -> frame_count=0.
REQ-029 Frame 17 beats, DEPTH=16, out_ready=0 -> drop_pulse once, drop_count=1 (macro on), frame_count=0, next 2-beat frame dst=1 delivered intact.
REQ-030 Frame 16 beats, DEPTH=16 -> no drop; s_ready=0 until first read.
REQ-031 1-beat frame committed same cycle as last beat of prior frame read -> frame_count stays 1.
REQ-032 reset asserted after 2 of 5 beats -> out_valid=0, frame_count=0, s_ready=1, next frame dst taken from its own first beat.

Source files
------------

// File: rtl/ingress_requester.sv
// ingress_requester: per-port ingress FIFO that only presents complete frames.
// A speculative write pointer collects a frame; it is committed on the last
// beat so out_valid never sees a partial frame. A frame that outgrows the FIFO
// is dropped and the rest of it is swallowed.
// Optional feature macro: INGRESS_DROP_CNT_EN (saturating dropped-frame counter).
//
// state   | meaning
// WR_HDR  | next accepted beat starts a frame and supplies dst
// WR_BODY | inside a frame, beats tagged with the latched dst
// WR_DROP | frame overflowed, discard beats until s_last
module ingress_requester #(
  parameter int N_PORTS    = 4,
  parameter int IDX_WIDTH  = $clog2(N_PORTS),
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      s_data,
  input  logic                       s_valid,
  input  logic                       s_last,
  output logic                       s_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [IDX_WIDTH-1:0]       out_dst,
  input  logic                       out_ready,
  output logic                       drop_pulse,
  output logic [15:0]                drop_count,
  output logic [$clog2(DEPTH):0]     frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = IDX_WIDTH + 1 + DATA_WIDTH;

  typedef enum logic [1:0] {WR_HDR, WR_BODY, WR_DROP} wr_state_t;

  wr_state_t state_q, state_d;

  logic [EW-1:0]        mem [DEPTH];
  logic [PW-1:0]        wr_spec_q, wr_com_q, rd_q, fc_q;
  logic [IDX_WIDTH-1:0] dst_q, wr_dst;
  logic [PW-1:0]        occupancy, uncommitted;
  logic                 full, overflow;
  logic                 do_write, do_commit, do_drop;
  logic                 rd_en, rd_last;

  assign occupancy   = wr_spec_q - rd_q;
  assign uncommitted = wr_spec_q - wr_com_q;
  assign full        = (occupancy == PW'(DEPTH));
  // Only a frame that alone fills the FIFO can never drain, so only then drop.
  assign overflow    = full && (uncommitted == PW'(DEPTH)) && (state_q != WR_DROP);
  assign wr_dst      = (state_q == WR_HDR) ? s_data[IDX_WIDTH-1:0] : dst_q;

  assign {out_dst, out_last, out_data} = mem[rd_q[AW-1:0]];
  assign out_valid   = (fc_q != '0);
  assign rd_en       = out_valid && out_ready;
  assign rd_last     = rd_en && out_last;
  assign frame_count = fc_q;

  // Write FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= WR_HDR;
    else       state_q <= state_d;
  end

  // Write FSM next state, acceptance and write/commit/drop decisions.
  always_comb begin
    state_d   = state_q;
    s_ready   = (state_q == WR_DROP) || !full || overflow;
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    case (state_q)
      WR_HDR, WR_BODY: begin
        if (s_valid && s_ready) begin
          if (overflow) begin
            do_drop = 1'b1;
            state_d = s_last ? WR_HDR : WR_DROP;
          end else begin
            do_write = 1'b1;
            if (s_last) begin
              do_commit = 1'b1;
              state_d   = WR_HDR;
            end else begin
              state_d = WR_BODY;
            end
          end
        end
      end
      WR_DROP: begin
        if (s_valid && s_last) state_d = WR_HDR;
      end
      default: state_d = WR_HDR;
    endcase
  end

  // Pointers, frame count, dst latch and drop pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_spec_q  <= '0;
      wr_com_q   <= '0;
      rd_q       <= '0;
      fc_q       <= '0;
      dst_q      <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= do_drop;
      if (do_write) begin
        wr_spec_q <= wr_spec_q + PW'(1);
        dst_q     <= wr_dst;
      end
      if (do_commit) wr_com_q  <= wr_spec_q + PW'(1);
      if (do_drop)   wr_spec_q <= wr_com_q;
      if (rd_en)     rd_q      <= rd_q + PW'(1);
      case ({do_commit, rd_last})
        2'b10:   fc_q <= fc_q + PW'(1);
        2'b01:   fc_q <= fc_q - PW'(1);
        default: fc_q <= fc_q;
      endcase
    end
  end

  // Beat storage; contents are not reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_spec_q[AW-1:0]] <= {wr_dst, s_last, s_data};
  end

`ifdef INGRESS_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped frames.
  always_ff @(posedge clk) begin
    if (reset)                                   drop_cnt_q <= '0;
    else if (drop_pulse && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_ingress_requester.sv
// Directed bench for ingress_requester: a vector table for streaming and
// commit/read overlap, plus sequences for hold-off, overflow drop, exact-fill
// and mid-frame reset.
module tb_ingress_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;
  logic [1:0] out_dst;
  logic       drop_pulse;
  logic [15:0] drop_count;
  logic [4:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef INGRESS_DROP_CNT_EN
  localparam int EXP_DROPS = 1;
`else
  localparam int EXP_DROPS = 0;
`endif

  ingress_requester dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_dst(out_dst), .out_ready(out_ready),
    .drop_pulse(drop_pulse), .drop_count(drop_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic       v, l, ordy;
    logic       e_srdy, e_ov;
    logic [7:0] e_data;
    logic       e_last;
    logic [1:0] e_dst;
    int         e_fc;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk($sformatf("send_ready_%02h", d), s_ready, 1);
    tick();
  endtask

  initial begin
    // streaming 3-beat frame with out_ready=1
    tbl[0]  = '{8'h02, 1, 0, 1, 1, 0, 8'h00, 0, 2'd0, 0};
    tbl[1]  = '{8'hA1, 1, 0, 1, 1, 0, 8'h00, 0, 2'd0, 0};
    tbl[2]  = '{8'hB2, 1, 1, 1, 1, 0, 8'h00, 0, 2'd0, 0};
    tbl[3]  = '{8'h00, 0, 0, 1, 1, 1, 8'h02, 0, 2'd2, 1};
    tbl[4]  = '{8'h00, 0, 0, 1, 1, 1, 8'hA1, 0, 2'd2, 1};
    tbl[5]  = '{8'h00, 0, 0, 1, 1, 1, 8'hB2, 1, 2'd2, 1};
    tbl[6]  = '{8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 2'd0, 0};
    // 1-beat frame committed while previous frame's last beat is read
    tbl[7]  = '{8'h01, 1, 0, 1, 1, 0, 8'h00, 0, 2'd0, 0};
    tbl[8]  = '{8'h11, 1, 1, 1, 1, 0, 8'h00, 0, 2'd0, 0};
    tbl[9]  = '{8'h00, 0, 0, 1, 1, 1, 8'h01, 0, 2'd1, 1};
    tbl[10] = '{8'h03, 1, 1, 1, 1, 1, 8'h11, 1, 2'd1, 1};
    tbl[11] = '{8'h00, 0, 0, 1, 1, 1, 8'h03, 1, 2'd3, 1};
    tbl[12] = '{8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 2'd0, 0};

    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
    chk("rst_drop_count", drop_count, 0);

    // table-driven vectors
    for (int i = 0; i < 13; i++) begin
      s_data = tbl[i].d; s_valid = tbl[i].v; s_last = tbl[i].l; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_s_ready", i), s_ready, tbl[i].e_srdy);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_frame_count", i), frame_count, tbl[i].e_fc);
      if (tbl[i].e_ov) begin
        chk($sformatf("v%0d_out_data", i), out_data, tbl[i].e_data);
        chk($sformatf("v%0d_out_last", i), out_last, tbl[i].e_last);
        chk($sformatf("v%0d_out_dst", i), out_dst, tbl[i].e_dst);
      end
      tick();
    end
    s_valid = 1'b0; out_ready = 1'b0;

    // 4-beat frame held off for 10 cycles, then drained
    send_beat(8'h03, 0); send_beat(8'h44, 0); send_beat(8'h55, 0); send_beat(8'h66, 1);
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("hold%0d_out_valid", k), out_valid, 1);
      chk($sformatf("hold%0d_frame_count", k), frame_count, 1);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] exp_d [4];
      exp_d = '{8'h03, 8'h44, 8'h55, 8'h66};
      #1;
      chk($sformatf("hold_rd%0d_data", k), out_data, exp_d[k]);
      chk($sformatf("hold_rd%0d_dst", k), out_dst, 3);
      chk($sformatf("hold_rd%0d_last", k), out_last, (k == 3));
      tick();
    end
    #1;
    chk("hold_end_frame_count", frame_count, 0);
    chk("hold_end_out_valid", out_valid, 0);
    out_ready = 1'b0;

    // 17-beat frame overflows a 16-entry FIFO
    send_beat(8'h00, 0);
    for (int k = 1; k < 16; k++) send_beat(8'h20 + 8'(k), 0);
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    #1;
    chk("ovf_s_ready", s_ready, 1);
    chk("ovf_pulse_before", drop_pulse, 0);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("ovf_drop_pulse", drop_pulse, 1);
    chk("ovf_frame_count", frame_count, 0);
    chk("ovf_out_valid", out_valid, 0);
    chk("ovf_s_ready_after", s_ready, 1);
    tick();
    #1;
    chk("ovf_pulse_single", drop_pulse, 0);
    chk("ovf_drop_count", drop_count, EXP_DROPS);
    out_ready = 1'b1;
    send_beat(8'h01, 0); send_beat(8'hC7, 1);
    s_valid = 1'b0;
    #1;
    chk("post_ovf_valid", out_valid, 1);
    chk("post_ovf_data0", out_data, 8'h01);
    chk("post_ovf_dst0", out_dst, 1);
    chk("post_ovf_last0", out_last, 0);
    tick();
    #1;
    chk("post_ovf_data1", out_data, 8'hC7);
    chk("post_ovf_dst1", out_dst, 1);
    chk("post_ovf_last1", out_last, 1);
    tick();
    #1;
    chk("post_ovf_empty", out_valid, 0);
    out_ready = 1'b0;

    // exactly 16 beats fill the FIFO without a drop
    for (int k = 0; k < 16; k++) send_beat(8'h40 + 8'(k), (k == 15));
    s_valid = 1'b0; s_last = 1'b0;
    #1;
    chk("fill_frame_count", frame_count, 1);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_s_ready", s_ready, 0);
    chk("fill_no_drop", drop_pulse, 0);
    tick();
    #1;
    chk("fill_s_ready_hold", s_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("fill_s_ready_same_cycle", s_ready, 0);
    chk("fill_rd0_data", out_data, 8'h40);
    tick();
    #1;
    chk("fill_s_ready_next", s_ready, 1);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("fill_rd%0d_data", k), out_data, 8'h40 + 8'(k));
      chk($sformatf("fill_rd%0d_last", k), out_last, (k == 15));
      tick();
      #1;
    end
    chk("fill_end_frame_count", frame_count, 0);
    out_ready = 1'b0;

    // reset in the middle of a frame with a committed frame also stored
    send_beat(8'h03, 1);
    send_beat(8'h01, 0); send_beat(8'h22, 0);
    s_valid = 1'b0;
    #1;
    chk("prerst_frame_count", frame_count, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_frame_count", frame_count, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_drop_pulse", drop_pulse, 0);
    chk("midrst_drop_count", drop_count, 0);
    out_ready = 1'b1;
    send_beat(8'h02, 0); send_beat(8'h33, 1);
    s_valid = 1'b0;
    #1;
    chk("midrst_rd0_valid", out_valid, 1);
    chk("midrst_rd0_data", out_data, 8'h02);
    chk("midrst_rd0_dst", out_dst, 2);
    chk("midrst_rd0_last", out_last, 0);
    tick();
    #1;
    chk("midrst_rd1_data", out_data, 8'h33);
    chk("midrst_rd1_dst", out_dst, 2);
    chk("midrst_rd1_last", out_last, 1);
    tick();
    #1;
    chk("midrst_empty", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
